tail_light_sched: RTL

- Controller/scheduler for the car tail-light lamp bank (3 lamps per side, l[2:0] / r[2:0]).
- Arbitrates among turn-left, turn-right, hazard and brake requests.
- Paces the lamp sequence with an internal step prescaler and drives the lamp outputs directly.
- Sits between debounced driver switches and the lamp drivers; a running sequence always completes before the next request is taken.

---
 rtl/tail_light_sched_pkg.sv | 28 ++
 rtl/tail_light_sched_if.sv | 16 +
 rtl/tail_light_sched_step_prescaler.sv | 25 ++
 rtl/tail_light_sched.sv | 90 +++++++++
 4 files changed

// File: rtl/tail_light_sched_pkg.sv
// Shared state encoding, lamp patterns and the brake-overlay helper for the tail-light scheduler.
package tail_light_pkg;

  localparam int DIV_DEFAULT = 4;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_L1    = 4'd1,
    S_L2    = 4'd2,
    S_L3    = 4'd3,
    S_R1    = 4'd4,
    S_R2    = 4'd5,
    S_R3    = 4'd6,
    S_H_ON  = 4'd7,
    S_H_OFF = 4'd8
  } state_t;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_P1  = 3'b001;
  localparam logic [2:0] LAMP_P2  = 3'b011;
  localparam logic [2:0] LAMP_P3  = 3'b111;

  // A side that is not running a turn pattern lights fully while braking.
  function automatic logic [2:0] side_out(logic [2:0] pat, logic turning, logic brk);
    return (brk && !turning) ? LAMP_P3 : pat;
  endfunction

endpackage

// File: rtl/tail_light_sched_if.sv
// Request inputs and lamp outputs of the tail-light scheduler, grouped as one bundle.
interface tail_light_sched_if;
  logic       left_req;
  logic       right_req;
  logic       hazard_req;
  logic       brake;
  logic [2:0] l;
  logic [2:0] r;
  logic       busy;
  logic       step;

  modport master (output left_req, right_req, hazard_req, brake,
                  input  l, r, busy, step);
  modport slave  (input  left_req, right_req, hazard_req, brake,
                  output l, r, busy, step);
endinterface

// File: rtl/tail_light_sched_step_prescaler.sv
// Free-running step prescaler: counts 0..DIV-1 and strobes step on the last count.
module step_prescaler
  import tail_light_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT,
  parameter int CW  = 16
) (
  input  logic clk,
  input  logic reset,
  output logic step
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign step = (r_cnt == LAST);

endmodule

// File: rtl/tail_light_sched.sv
// Tail-light scheduler: arbitrates turn/hazard requests once per step and decodes lamps with brake overlay.
module tail_light_sched
  import tail_light_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  tail_light_sched_if.slave bus
);

  logic       w_step;
  state_t     w_next;
  state_t     r_state;
  logic       r_brake_q;
  logic       r_busy;
  logic [2:0] w_l_pat;
  logic [2:0] w_r_pat;
  logic       w_l_turn;
  logic       w_r_turn;

  step_prescaler #(.DIV(DIV), .CW(CW)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .step  (w_step)
  );

  // Requests are only looked at from IDLE; running sequences always complete.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.hazard_req || (bus.left_req && bus.right_req)) w_next = S_H_ON;
        else if (bus.left_req)                                 w_next = S_L1;
        else if (bus.right_req)                                w_next = S_R1;
        else                                                   w_next = S_IDLE;
      end
      S_L1:    w_next = S_L2;
      S_L2:    w_next = S_L3;
      S_L3:    w_next = S_IDLE;
      S_R1:    w_next = S_R2;
      S_R2:    w_next = S_R3;
      S_R3:    w_next = S_IDLE;
      S_H_ON:  w_next = S_H_OFF;
      S_H_OFF: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_brake_q <= 1'b0;
    end else begin
      r_brake_q <= bus.brake;
      if (w_step) begin
        r_state <= w_next;
        r_busy  <= (w_next != S_IDLE);
      end
    end
  end

  always_comb begin
    w_l_pat  = LAMP_OFF;
    w_r_pat  = LAMP_OFF;
    w_l_turn = 1'b0;
    w_r_turn = 1'b0;
    case (r_state)
      S_L1:   begin w_l_pat = LAMP_P1; w_l_turn = 1'b1; end
      S_L2:   begin w_l_pat = LAMP_P2; w_l_turn = 1'b1; end
      S_L3:   begin w_l_pat = LAMP_P3; w_l_turn = 1'b1; end
      S_R1:   begin w_r_pat = LAMP_P1; w_r_turn = 1'b1; end
      S_R2:   begin w_r_pat = LAMP_P2; w_r_turn = 1'b1; end
      S_R3:   begin w_r_pat = LAMP_P3; w_r_turn = 1'b1; end
      S_H_ON: begin w_l_pat = LAMP_P3; w_r_pat = LAMP_P3; end
      default: begin
        w_l_pat = LAMP_OFF;
        w_r_pat = LAMP_OFF;
      end
    endcase
  end

  assign bus.l    = side_out(w_l_pat, w_l_turn, r_brake_q);
  assign bus.r    = side_out(w_r_pat, w_r_turn, r_brake_q);
  assign bus.busy = r_busy;
  assign bus.step = w_step;

endmodule
